// File: rtl/lif_membrane_acc_if.sv
// Handshake/data bundle between the LIF membrane accumulator and its environment.
//   start     : one-cycle pulse that begins a timestep
//   spk_in    : presynaptic spike vector, bit i gates weight i
//   weights   : packed signed 8-bit weights, weight i = weights[8*i+7:8*i]
//   spk       : downstream comparator result, combinational on acc_out
//   acc_out   : membrane potential register (0..V_MAX)
//   acc_valid : high only while spk is being sampled
//   busy      : high whenever the accumulator is not idle
//   done      : one-cycle end-of-timestep pulse
//   spk_out   : neuron spike for this timestep, valid while done is high
// master = stimulus/comparator side, slave = accumulator side.
interface lif_membrane_acc_if #(
   parameter int unsigned N_IN = 8
);
   logic                start;
   logic [N_IN-1:0]     spk_in;
   logic [8*N_IN-1:0]   weights;
   logic                spk;
   logic [7:0]          acc_out;
   logic                acc_valid;
   logic                busy;
   logic                done;
   logic                spk_out;

   modport master (
      output start, spk_in, weights, spk,
      input  acc_out, acc_valid, busy, done, spk_out
   );

   modport slave (
      input  start, spk_in, weights, spk,
      output acc_out, acc_valid, busy, done, spk_out
   );
endinterface

// File: rtl/lif_membrane_acc.sv
// Leaky integrate-and-fire membrane accumulator for a single neuron.
// Each timestep serially adds the spike-gated weights (clamped to 0..V_MAX after every add),
// applies a shift-based leak, then samples the external comparator's spk in one EVAL cycle.
// A spike clears the membrane and starts a refractory period of REFRAC timesteps during
// which start pulses only produce an empty done.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_io : lif_membrane_acc_if slave modport (start/spk_in/weights/spk in,
//            acc_out/acc_valid/busy/done/spk_out out)
module lif_membrane_acc #(
   parameter int unsigned N_IN       = 8,
   parameter int unsigned LEAK_SHIFT = 3,
   parameter int unsigned REFRAC     = 2,
   parameter int unsigned V_MAX      = 127
) (
   input  logic                 clk,
   input  logic                 rst_n,
   lif_membrane_acc_if.slave    bus_io
);

   localparam int unsigned     IdxW       = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned     RcW        = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam logic [7:0]      VMax       = 8'(V_MAX);
   localparam logic [IdxW-1:0] IdxLast    = IdxW'(N_IN - 1);
   localparam logic [RcW-1:0]  RefracInit = RcW'(REFRAC);

   typedef enum logic [2:0] {
      StIdle,
      StInteg,
      StLeak,
      StEval,
      StFin,
      StRefr
   } state_e;

   state_e              state_q;
   logic [7:0]          v_q;
   logic [RcW-1:0]      refrac_q;
   logic [IdxW-1:0]     idx_q;
   logic [N_IN-1:0]     spk_lat_q;
   logic [8*N_IN-1:0]   w_lat_q;
   logic                acc_valid_q;
   logic                busy_q;
   logic                done_q;
   logic                spk_out_q;

   logic [7:0]          w_sel;
   logic signed [8:0]   sum;
   logic [7:0]          v_add;
   logic [7:0]          v_leak;

   // 9-bit signed add covers 0..127 plus -128..127 without overflow.
   always_comb begin
      w_sel = w_lat_q[{idx_q, 3'b000} +: 8];
      sum   = $signed({1'b0, v_q}) + $signed({w_sel[7], w_sel});
      if (sum[8]) begin
         v_add = '0;
      end else if (sum[7:0] > VMax) begin
         v_add = VMax;
      end else begin
         v_add = sum[7:0];
      end
      // v_q is never negative, so a logical shift is the right leak.
      v_leak = v_q - (v_q >> LEAK_SHIFT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         v_q         <= '0;
         refrac_q    <= '0;
         idx_q       <= '0;
         spk_lat_q   <= '0;
         w_lat_q     <= '0;
         acc_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         spk_out_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus_io.start) begin
                  busy_q <= 1'b1;
                  if (refrac_q == '0) begin
                     spk_lat_q <= bus_io.spk_in;
                     w_lat_q   <= bus_io.weights;
                     idx_q     <= '0;
                     state_q   <= StInteg;
                  end else begin
                     state_q <= StRefr;
                  end
               end
            end
            StInteg: begin
               if (spk_lat_q[idx_q]) begin
                  v_q <= v_add;
               end
               if (idx_q == IdxLast) begin
                  state_q <= StLeak;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            StLeak: begin
               v_q         <= v_leak;
               acc_valid_q <= 1'b1;
               state_q     <= StEval;
            end
            StEval: begin
               // spk_out_q doubles as the latched spike for the FIN cycle.
               acc_valid_q <= 1'b0;
               done_q      <= 1'b1;
               spk_out_q   <= bus_io.spk;
               if (bus_io.spk) begin
                  v_q      <= '0;
                  refrac_q <= RefracInit;
               end
               state_q <= StFin;
            end
            StFin: begin
               done_q    <= 1'b0;
               spk_out_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= StIdle;
            end
            StRefr: begin
               refrac_q  <= refrac_q - 1'b1;
               done_q    <= 1'b1;
               spk_out_q <= 1'b0;
               state_q   <= StFin;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus_io.acc_out   = v_q;
   assign bus_io.acc_valid = acc_valid_q;
   assign bus_io.busy      = busy_q;
   assign bus_io.done      = done_q;
   assign bus_io.spk_out   = spk_out_q;

endmodule

// File: tb/tb_lif_membrane_acc.sv
// Self-checking bench for lif_membrane_acc: directed scenarios plus randomized timesteps,
// checked against a timestep-level arithmetic model of the neuron.
module tb_lif_membrane_acc;

   localparam int unsigned N_IN       = 8;
   localparam int unsigned LEAK_SHIFT = 3;
   localparam int unsigned REFRAC     = 2;
   localparam int unsigned V_MAX      = 127;

   typedef struct packed {
      int   cycles;
      int   n_valid;
      int   eval_acc;
      logic eval_spk;
      int   done_acc;
      logic done_spk;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;
   int   thr = 100;
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_v = 0;
   int   m_ref = 0;

   always #5 clk = ~clk;

   lif_membrane_acc_if #(.N_IN(N_IN)) bus ();

   // Downstream threshold comparator.
   assign bus.spk = (int'(bus.acc_out) >= thr);

   lif_membrane_acc #(
      .N_IN      (N_IN),
      .LEAK_SHIFT(LEAK_SHIFT),
      .REFRAC    (REFRAC),
      .V_MAX     (V_MAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_io(bus)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   function automatic string fmt(input obs_t o);
      return $sformatf("cyc=%0d nvalid=%0d eval_acc=%0d eval_spk=%0b done_acc=%0d done_spk=%0b",
                       o.cycles, o.n_valid, o.eval_acc, o.eval_spk, o.done_acc, o.done_spk);
   endfunction

   // Whole-timestep reference: integrate with per-add clamp, leak, compare, refractory.
   function automatic obs_t model_step(input logic [N_IN-1:0] s, input logic [8*N_IN-1:0] w);
      obs_t e;
      if (m_ref > 0) begin
         m_ref--;
         e.cycles   = 2;
         e.n_valid  = 0;
         e.eval_acc = -1;
         e.eval_spk = 1'b0;
         e.done_acc = m_v;
         e.done_spk = 1'b0;
      end else begin
         for (int i = 0; i < int'(N_IN); i++) begin
            if (s[i]) begin
               m_v = m_v + int'($signed(w[8*i +: 8]));
               if (m_v < 0) m_v = 0;
               if (m_v > int'(V_MAX)) m_v = int'(V_MAX);
            end
         end
         m_v = m_v - m_v / (2 ** LEAK_SHIFT);
         e.cycles   = N_IN + 3;
         e.n_valid  = 1;
         e.eval_acc = m_v;
         e.eval_spk = (m_v >= thr);
         if (e.eval_spk) begin
            m_v   = 0;
            m_ref = REFRAC;
         end
         e.done_acc = m_v;
         e.done_spk = e.eval_spk;
      end
      return e;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge right after done.
   task automatic run_step(input logic [N_IN-1:0] s, input logic [8*N_IN-1:0] w,
                           output obs_t o);
      o = '{cycles: 0, n_valid: 0, eval_acc: -1, eval_spk: 1'b0, done_acc: -1,
            done_spk: 1'b0};
      bus.start   = 1'b1;
      bus.spk_in  = s;
      bus.weights = w;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.acc_valid) begin
            o.n_valid++;
            o.eval_acc = int'(bus.acc_out);
            o.eval_spk = bus.spk;
         end
         if (bus.done) begin
            o.cycles   = c;
            o.done_acc = int'(bus.acc_out);
            o.done_spk = bus.spk_out;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_v   = 0;
      m_ref = 0;
      @(negedge clk);
   endtask

   function automatic logic [8*N_IN-1:0] fill_w(input int val);
      logic [8*N_IN-1:0] w;
      for (int i = 0; i < int'(N_IN); i++) w[8*i +: 8] = 8'(val);
      return w;
   endfunction

   task automatic test_reset();
      logic [11:0] outs;
      int          n_done = 0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.spk_in  = '0;
      bus.weights = '0;
      #12;
      outs = {bus.acc_out, bus.acc_valid, bus.busy, bus.done, bus.spk_out};
      n_checks++;
      if (outs !== 12'h000) begin
         n_errors++;
         $display("FAIL reset_state: outputs=%h required 000", outs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // Begin a step and pull reset while in INTEG.
      bus.start   = 1'b1;
      bus.spk_in  = '1;
      bus.weights = fill_w(20);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.acc_out === 8'd0) begin
         n_errors++;
         $display("FAIL reset_pre_busy: busy=%b acc_out=%0d required busy=1 acc_out>0",
                  bus.busy, bus.acc_out);
      end
      #2 rst_n = 1'b0;
      #1;
      outs = {bus.acc_out, bus.acc_valid, bus.busy, bus.done, bus.spk_out};
      n_checks++;
      if (outs !== 12'h000) begin
         n_errors++;
         $display("FAIL reset_async: outputs=%h required 000", outs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (bus.done) n_done++;
         @(negedge clk);
      end
      n_checks++;
      if (n_done !== 0 || bus.busy !== 1'b0 || bus.acc_out !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_after: dones=%0d busy=%b acc_out=%0d required 0 0 0",
                  n_done, bus.busy, bus.acc_out);
      end
      m_v   = 0;
      m_ref = 0;
   endtask

   task automatic test_subthreshold();
      obs_t got, exp;
      thr = 100;
      exp = model_step('1, fill_w(10));
      run_step('1, fill_w(10), got);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL subthreshold: got %s required %s", fmt(got), fmt(exp));
      end
      n_checks++;
      if (got.eval_acc !== 70 || got.cycles !== 11 || got.eval_spk !== 1'b0) begin
         n_errors++;
         $display("FAIL subthreshold_const: eval_acc=%0d cyc=%0d spk=%0b required 70 11 0",
                  got.eval_acc, got.cycles, got.eval_spk);
      end
   endtask

   task automatic test_saturate_fire();
      obs_t got, exp;
      exp = model_step('1, fill_w(10));
      run_step('1, fill_w(10), got);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL saturate_fire: got %s required %s", fmt(got), fmt(exp));
      end
      n_checks++;
      if (got.eval_acc !== 112 || got.done_spk !== 1'b1 || got.done_acc !== 0) begin
         n_errors++;
         $display("FAIL saturate_fire_const: eval_acc=%0d spk_out=%0b acc=%0d required 112 1 0",
                  got.eval_acc, got.done_spk, got.done_acc);
      end
      // spk_out must drop with done.
      n_checks++;
      if (bus.spk_out !== 1'b0 || bus.done !== 1'b0) begin
         n_errors++;
         $display("FAIL spk_out_pulse: spk_out=%b done=%b required 0 0", bus.spk_out, bus.done);
      end
   endtask

   task automatic test_refractory();
      obs_t              got, exp;
      logic [N_IN-1:0]   s;
      logic [8*N_IN-1:0] w;
      for (int k = 0; k < 3; k++) begin
         s = N_IN'($urandom);
         w = fill_w(0);
         for (int i = 0; i < int'(N_IN); i++) w[8*i +: 8] = 8'($urandom_range(0, 60));
         exp = model_step(s, w);
         run_step(s, w, got);
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL refractory_step%0d: got %s required %s", k, fmt(got), fmt(exp));
         end
      end
   endtask

   task automatic test_negative_sparse();
      obs_t              got, exp;
      logic [8*N_IN-1:0] w;
      do_reset();
      exp = model_step('1, fill_w(-5));
      run_step('1, fill_w(-5), got);
      n_checks++;
      if (got !== exp || got.eval_acc !== 0) begin
         n_errors++;
         $display("FAIL negative_clamp: got %s required %s", fmt(got), fmt(exp));
      end
      w = fill_w(100);
      w[7:0]   = 8'd20;
      w[23:16] = 8'd30;
      exp = model_step(8'b0000_0101, w);
      run_step(8'b0000_0101, w, got);
      n_checks++;
      if (got !== exp || got.eval_acc !== 44) begin
         n_errors++;
         $display("FAIL sparse: got %s required %s", fmt(got), fmt(exp));
      end
   endtask

   task automatic test_handshake();
      obs_t              exp;
      logic [N_IN-1:0]   s;
      logic [8*N_IN-1:0] w;
      int                n_done = 0;
      int                done_cyc = 0;
      int                eval_acc = -1;
      logic              done_spk = 1'b0;
      do_reset();
      thr = 127;
      s   = N_IN'($urandom);
      w   = {$urandom, $urandom};
      exp = model_step(s, w);
      bus.start   = 1'b1;
      bus.spk_in  = s;
      bus.weights = w;
      @(negedge clk);
      for (int c = 1; c <= 16; c++) begin
         if (bus.acc_valid) eval_acc = int'(bus.acc_out);
         if (bus.done) begin
            n_done++;
            done_cyc = c;
            done_spk = bus.spk_out;
         end
         // Extra starts land in INTEG, LEAK and EVAL; inputs churn after the latch.
         bus.start   = (c == 2 || c == 5 || c == 9 || c == 10);
         bus.spk_in  = ~bus.spk_in;
         bus.weights = {$urandom, $urandom};
         @(negedge clk);
      end
      bus.start = 1'b0;
      n_checks++;
      if (n_done !== 1 || done_cyc !== 11) begin
         n_errors++;
         $display("FAIL handshake_done: dones=%0d at=%0d required 1 at 11", n_done, done_cyc);
      end
      n_checks++;
      if (eval_acc !== exp.eval_acc || done_spk !== exp.done_spk) begin
         n_errors++;
         $display("FAIL handshake_result: eval_acc=%0d spk_out=%0b required %0d %0b",
                  eval_acc, done_spk, exp.eval_acc, exp.done_spk);
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL handshake_idle: busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_random();
      obs_t              got, exp;
      logic [N_IN-1:0]   s;
      logic [8*N_IN-1:0] w;
      for (int k = 0; k < 40; k++) begin
         thr = $urandom_range(20, 127);
         s   = N_IN'($urandom);
         for (int i = 0; i < int'(N_IN); i++) begin
            w[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 50));
         end
         exp = model_step(s, w);
         run_step(s, w, got);
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL random_step%0d: got %s required %s", k, fmt(got), fmt(exp));
         end
      end
   endtask

   initial begin
      test_reset();
      test_subthreshold();
      test_saturate_fire();
      test_refractory();
      test_negative_sparse();
      test_handshake();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lif_membrane_acc.md
# lif_membrane_acc

Leaky integrate-and-fire membrane accumulator for one layer-2 neuron. Each timestep it serially integrates the weighted input spike vector, applies a shift-based leak, and presents the membrane potential on `acc_out` to the downstream threshold comparator. It samples the comparator's `spk` result in a dedicated evaluation cycle. On a spike it resets the membrane and enters a refractory period.

## Interface

Parameters:
- `N_IN`, 8: number of presynaptic inputs (≥1).
- `LEAK_SHIFT`, 3: leak = `v >> LEAK_SHIFT`, subtracted once per timestep.
- `REFRAC`, 2: number of timesteps ignored after a spike (0 = none).
- `V_MAX`, 127: upper clamp of membrane potential. Must be ≤127 so the comparator's 8-bit signed subtraction is valid.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a timestep; honoured only in IDLE.
- `spk_in` in N_IN: input spike vector; bit i gates weight i.
- `weights` in 8*N_IN: signed 8-bit weights; weight i = `weights[8*i+7:8*i]`.
- `spk` in 1: comparator output, computed combinationally from `acc_out`.
- `acc_out` out 8: membrane potential register, range 0..V_MAX.
- `acc_valid` out 1: high only in EVAL; marks `spk` as meaningful.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of a timestep.
- `spk_out` out 1: registered neuron spike, valid while `done` is high. It is 0 otherwise.

## Operation

- States: IDLE, INTEG, LEAK, EVAL, FIN, REFR.
- **IDLE**
  - On `start`, if `refrac_cnt == 0`: latch `spk_in` and `weights` into internal registers, set `idx = 0`, and go to INTEG.
  - On `start`, if `refrac_cnt > 0`: go to REFR.
  - When `start` is not asserted, stay in IDLE.
- **INTEG**: one input per cycle, for `idx` = 0..N_IN-1.
  - If the latched spike bit is set: `v <= clamp(v + w[idx], 0, V_MAX)`, computed at 9-bit signed width.
  - After `idx == N_IN-1`, go to LEAK.
- **LEAK**: `v <= v - (v >> LEAK_SHIFT)`. `v` is non-negative, so the shift is logical. Then go to EVAL.
- **EVAL**: assert `acc_valid` and sample `spk`.
  - If `spk`: `v <= 0`, `refrac_cnt <= REFRAC`, and latch spike = 1.
  - Else: latch spike = 0.
  - Go to FIN.
- **FIN**: `done = 1`, `spk_out = latched spike`. Then go to IDLE.
- **REFR**: `refrac_cnt <= refrac_cnt - 1`. `v` is unchanged (it is 0 after a spike). Go to FIN with `spk_out = 0`.
- `start` while `busy` is ignored and has no side effects.
- `spk_in` and `weights` changes after the latch cycle have no effect on the current timestep.
- The `refrac_cnt` width holds REFRAC.

## Timing

- **Reset** (`rst_n` low, asynchronous): state = IDLE, `v = 0`, `refrac_cnt = 0`, `idx = 0`.
  - Outputs: `acc_out = 0`, `acc_valid = 0`, `busy = 0`, `done = 0`, `spk_out = 0`.
- **Reset mid-timestep**: the operation aborts immediately, no `done` is produced, and the membrane is cleared.
- **Normal timestep**, with `start` sampled at edge 0:
  - INTEG occupies cycles 1..N_IN.
  - LEAK at N_IN+1.
  - EVAL at N_IN+2.
  - `done` at N_IN+3.
  - The next `start` is accepted at N_IN+4.
- **Refractory timestep**: REFR at cycle 1, `done` at cycle 2.
- **Comparator path**: `acc_out` is a register output. The comparator path is combinational, so `spk` is sampled in the same EVAL cycle with no extra latency.
- **Clamping**:
  - A negative sum floors at 0.
  - A sum greater than V_MAX saturates at V_MAX at each add, not only at the end.

## Test plan

- **Reset**: assert `rst_n = 0` mid-INTEG. All outputs go to 0 immediately. After release, `busy = 0`, `acc_out = 0`, and no `done` is seen.
- **Sub-threshold step**: N_IN=8, all spikes, all weights +10, threshold 100. EVAL shows `acc_out = 70` (80 − 10) with `spk = 0`. `done` arrives 11 cycles after `start` with `spk_out = 0`.
- **Saturation and fire**: repeat the sub-threshold step. The sum 150 clamps to 127, leak gives 112, and `spk = 1`. At `done`, `spk_out = 1` and `acc_out = 0`.
- **Refractory**:
  - The next two `start` pulses each produce `done` 2 cycles later, with `spk_out = 0` and `acc_out = 0`. Spikes presented during these steps are ignored.
  - The third `start` performs normal integration.
- **Negative clamp and sparse input**:
  - Weights all −5, all spikes, from `v = 0`: `acc_out` stays 0.
  - Then `spk_in = 8'b00000101` with w0 = 20, w2 = 30, and all other weights 100: EVAL shows `acc_out = 44`.
- **Handshake**:
  - `start` pulses during INTEG and LEAK are ignored: exactly one `done` is produced, at cycle 11.
  - `spk_in` is toggled after the latch cycle: the result is unchanged.
